serial_add_sub_digit: RTL and testbench
=======================================

# serial_add_sub_digit

Parametrised digit-serial adder/subtractor: consumes two operands one W-bit digit per valid cycle, least-significant digit first, and produces one registered result digit per consumed digit. It is the multi-bit, mode-selectable successor of the single-bit serial adder. Words are framed by `last`, with per-word carry-out, signed overflow and word-length error reporting. It sits in streaming datapaths between digit-serial producers and consumers.

## Interface
Parameters:
- `W`, 4: digit width in bits (>= 1).
- `MAX_DIGITS`, 16: maximum digits per word (>= 1); the digit counter is `$clog2(MAX_DIGITS+1)` bits.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous active-high reset.
- `vld` input 1: input digit valid.
- `sub` input 1: mode, 0 = a+b, 1 = a-b; sampled only on the first digit of a word.
- `a` input W: operand A digit.
- `b` input W: operand B digit.
- `last` input 1: current digit is the most significant digit of the word; ignored when `vld`=0.
- `out_vld` output 1: result digit valid.
- `sum` output W: result digit.
- `out_last` output 1: result digit is the last digit of the word.
- `cout` output 1: carry out of the word's MSB; valid only with `out_vld & out_last`, else 0.
- `ovf` output 1: two's-complement overflow of the word; valid only with `out_vld & out_last`, else 0.
- `len_err` output 1: word was truncated at `MAX_DIGITS`; valid only with `out_vld & out_last`, else 0.

## Operation
- States: `IDLE` (next valid digit is a word's first digit) and `BUSY` (mid-word).
- First digit (`IDLE & vld`): latch `mode = sub`; carry-in = `sub`; digit count = 1.
- Later digits (`BUSY & vld`): use latched `mode` and the stored carry; `sub` is ignored; count increments.
- Digit arithmetic, W+1 bits: `{c, s} = a + (b ^ {W{mode}}) + cin`; `s` goes to `sum`, `c` is stored as the next carry.
- Word end happens on `vld & last`, or on `vld` with count = `MAX_DIGITS` and `last`=0. At word end: `cout = c`. In subtract mode `cout`=1 means no borrow. `ovf = (a[W-1] == b'[W-1]) & (s[W-1] != a[W-1])` with `b' = b ^ {W{mode}}`. `len_err` = 1 only for the `MAX_DIGITS` truncation case. Then carry and count clear and the state returns to `IDLE`.
- After a truncation, the next valid digit starts a new word; no digits are dropped.
- `vld`=0: state, carry, count and mode hold.
- `MAX_DIGITS`=1: every valid digit is a complete word.
- `rst`: state `IDLE`, carry 0, count 0, mode 0, all outputs 0. Reset mid-word discards the partial word; no `out_last` is produced for it.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and are valid during cycle N+1.
- Throughput: one digit per cycle, with no stalls and no backpressure.
- Back-to-back words are allowed: the digit after a `last` digit may arrive in the very next cycle with a different `sub`.
- When `out_vld`=0, all of `sum`, `out_last`, `cout`, `ovf` and `len_err` are 0.
- Reset value of every output is 0, visible the cycle after `rst` is sampled high.
- `rst` and `vld` high together: reset wins and the digit is discarded.

## Configuration
- Macro `SERIAL_ADD_SUB_OVF_EN`.
- Defined: `ovf` is computed as described in Operation.
- Undefined: `ovf` is tied to 0 and the overflow logic is not synthesised. All other outputs are unchanged.

## Test plan
Digits below are listed LSB first, with `W`=4.
- Add with carry ripple: `sub`=0, a = 4,3,2,1 and b = F,F,F,0 with `last` on the 4th digit -> `sum` = 3,3,2,2 (0x2233), `out_last` on the 4th output, `cout`=0, `ovf`=0, `len_err`=0.
- Subtract with borrow: `sub`=1 on the first digit only, a = 5,0 and b = 7,0 -> `sum` = E,F (0xFE), `cout`=0, `ovf`=0. Repeat with `sub` toggled on the 2nd digit -> identical result.
- Signed overflow (macro defined): add a = 0,7 and b = 0,1 -> `sum` = 0,8, `ovf`=1, `cout`=0. Same stimulus with the macro undefined -> `ovf`=0.
- Valid gaps: repeat the first scenario with `vld`=0 for 2 cycles between each digit -> same `sum` sequence, `out_vld`=0 and all outputs 0 during gaps. Then issue a back-to-back single-digit word F+1 -> `sum`=0, `cout`=1, `out_last`=1.
- Length error: `MAX_DIGITS`=4, five digits of 1+1 with no `last` -> outputs 2,2,2,2 with `out_last`=1 and `len_err`=1 on the 4th. The 5th digit gives `sum`=2 as the first digit of a new word (carry-in 0).
- Reset mid-word: `sub`=1, two digits accepted, then `rst` for 1 cycle -> all outputs 0. Then single-digit add F+1 with `last` -> `sum`=0, `cout`=1, proving mode and carry were cleared.

Source files
------------

// File: rtl/serial_add_sub_digit.sv
// Digit-serial a+b / a-b, LSB digit first, words framed by last; ovf only with SERIAL_ADD_SUB_OVF_EN.
// One registered result digit per valid input digit, 1-cycle latency, always accepts (no backpressure).
module serial_add_sub_digit #(
  parameter int W          = 4,
  parameter int MAX_DIGITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         last,
  output logic         out_vld,
  output logic [W-1:0] sum,
  output logic         out_last,
  output logic         cout,
  output logic         ovf,
  output logic         len_err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;

  logic          out_vld_q, out_vld_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          out_last_q, out_last_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          len_err_q, len_err_d;

  logic          first;
  logic          mode_eff;
  logic          cin;
  logic [CW-1:0] cnt_eff;
  logic [W-1:0]  b_x;
  logic [W-1:0]  s;
  logic          c;
  logic          at_max;
  logic          word_end;

  always_comb begin
    state_d    = state_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    out_vld_d  = 1'b0;
    sum_d      = '0;
    out_last_d = 1'b0;
    cout_d     = 1'b0;
    ovf_d      = 1'b0;
    len_err_d  = 1'b0;

    // The first digit of a word takes its mode and carry-in straight from sub.
    first    = (state_q == IDLE);
    mode_eff = first ? sub : mode_q;
    cin      = first ? sub : carry_q;
    cnt_eff  = first ? CW'(1) : cnt_q + CW'(1);
    b_x      = b ^ {W{mode_eff}};
    {c, s}   = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, cin};
    at_max   = (cnt_eff == MAX_CNT);
    word_end = last || at_max;

    if (vld) begin
      out_vld_d = 1'b1;
      sum_d     = s;
      if (word_end) begin
        out_last_d = 1'b1;
        cout_d     = c;
        len_err_d  = at_max && !last;
`ifdef SERIAL_ADD_SUB_OVF_EN
        ovf_d      = (a[W-1] == b_x[W-1]) && (s[W-1] != a[W-1]);
`else
        ovf_d      = 1'b0;
`endif
        state_d    = IDLE;
        carry_d    = 1'b0;
        cnt_d      = '0;
        mode_d     = mode_eff;
      end else begin
        state_d = BUSY;
        carry_d = c;
        cnt_d   = cnt_eff;
        mode_d  = mode_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      out_vld_q  <= 1'b0;
      sum_q      <= '0;
      out_last_q <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      out_vld_q  <= out_vld_d;
      sum_q      <= sum_d;
      out_last_q <= out_last_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      len_err_q  <= len_err_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign sum      = sum_q;
  assign out_last = out_last_q;
  assign cout     = cout_q;
  assign ovf      = ovf_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_serial_add_sub_digit.sv
// Bench for serial_add_sub_digit (W=4, MAX_DIGITS=4): directed scenarios plus random words vs a whole-word model.
module tb_serial_add_sub_digit;

  logic       clk;
  logic       rst;
  logic       vld;
  logic       sub;
  logic [3:0] a;
  logic [3:0] b;
  logic       last;
  logic       out_vld;
  logic [3:0] sum;
  logic       out_last;
  logic       cout;
  logic       ovf;
  logic       len_err;

  int passed = 0;
  int total  = 0;

`ifdef SERIAL_ADD_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // Word buffers for the reference model; observation layout is {vld, sum, last, cout, ovf, len_err}.
  logic [3:0] wa [4];
  logic [3:0] wb [4];
  logic [8:0] ex [4];

  serial_add_sub_digit #(.W(4), .MAX_DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .last     (last),
    .out_vld  (out_vld),
    .sum      (sum),
    .out_last (out_last),
    .cout     (cout),
    .ovf      (ovf),
    .len_err  (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic s, input logic [3:0] ia,
                      input logic [3:0] ib, input logic il, output logic [8:0] o);
    @(negedge clk);
    rst = r; vld = v; sub = s; a = ia; b = ib; last = il;
    @(posedge clk);
    #1;
    o = {out_vld, sum, out_last, cout, ovf, len_err};
  endtask

  // Whole-word arithmetic: A + (mode ? ~B : B) + mode over 4*n bits, then sliced into digits.
  task automatic model_word(input int n, input bit mode, input bit trunc);
    int A, B, Bp, R, top;
    bit fin, sa, sb, sr;
    A = 0;
    B = 0;
    for (int i = 0; i < n; i++) begin
      A = A | (int'(wa[i]) << (4 * i));
      B = B | (int'(wb[i]) << (4 * i));
    end
    Bp  = mode ? (~B & ((1 << (4 * n)) - 1)) : B;
    R   = A + Bp + int'(mode);
    top = 4 * n - 1;
    sa  = A[top];
    sb  = Bp[top];
    sr  = R[top];
    for (int i = 0; i < n; i++) begin
      fin   = (i == n - 1);
      ex[i] = {1'b1, 4'(R >> (4 * i)), fin, fin & R[4 * n],
               fin & OVF_ON & (sa == sb) & (sr != sa), fin & trunc};
    end
  endtask

  task automatic test_reset();
    logic [8:0] o;
    step(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, o);
    total++;
    if (o !== 9'h000) $display("FAIL reset_with_vld got %h want %h", o, 9'h000);
    else passed++;
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, o);
    total++;
    if (o !== 9'h000) $display("FAIL reset_idle got %h want %h", o, 9'h000);
    else passed++;
  endtask

  task automatic test_add_ripple();
    logic [3:0] da [4];
    logic [3:0] db [4];
    logic [3:0] ds [4];
    logic [8:0] o, e;
    da = '{4'h4, 4'h3, 4'h2, 4'h1};
    db = '{4'hF, 4'hF, 4'hF, 4'h0};
    ds = '{4'h3, 4'h3, 4'h2, 4'h2};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, da[i], db[i], i == 3, o);
      e = {1'b1, ds[i], i == 3, 3'b000};
      total++;
      if (o !== e) $display("FAIL add_ripple d%0d got %h want %h", i, o, e);
      else passed++;
    end
  endtask

  task automatic test_sub_borrow();
    logic [8:0] o, e;
    for (int p = 0; p < 2; p++) begin
      step(1'b0, 1'b1, 1'b1, 4'h5, 4'h7, 1'b0, o);
      e = {1'b1, 4'hE, 4'b0000};
      total++;
      if (o !== e) $display("FAIL sub_borrow p%0d d0 got %h want %h", p, o, e);
      else passed++;
      step(1'b0, 1'b1, (p == 0), 4'h0, 4'h0, 1'b1, o);
      e = {1'b1, 4'hF, 4'b1000};
      total++;
      if (o !== e) $display("FAIL sub_borrow p%0d d1 got %h want %h", p, o, e);
      else passed++;
    end
  endtask

  task automatic test_ovf();
    logic [8:0] o, e;
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, o);
    e = {1'b1, 4'h0, 4'b0000};
    total++;
    if (o !== e) $display("FAIL ovf d0 got %h want %h", o, e);
    else passed++;
    step(1'b0, 1'b1, 1'b0, 4'h7, 4'h1, 1'b1, o);
    e = {1'b1, 4'h8, 1'b1, 1'b0, OVF_ON, 1'b0};
    total++;
    if (o !== e) $display("FAIL ovf d1 got %h want %h", o, e);
    else passed++;
  endtask

  task automatic test_gaps();
    logic [3:0] da [4];
    logic [3:0] db [4];
    logic [3:0] ds [4];
    logic [8:0] o, e;
    da = '{4'h4, 4'h3, 4'h2, 4'h1};
    db = '{4'hF, 4'hF, 4'hF, 4'h0};
    ds = '{4'h3, 4'h3, 4'h2, 4'h2};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, da[i], db[i], i == 3, o);
      e = {1'b1, ds[i], i == 3, 3'b000};
      total++;
      if (o !== e) $display("FAIL gaps d%0d got %h want %h", i, o, e);
      else passed++;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'b1, o);
          total++;
          if (o !== 9'h000) $display("FAIL gaps idle d%0d g%0d got %h want %h", i, g, o, 9'h000);
          else passed++;
        end
      end
    end
    step(1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 1'b1, o);
    e = {1'b1, 4'h0, 4'b1100};
    total++;
    if (o !== e) $display("FAIL back_to_back got %h want %h", o, e);
    else passed++;
  endtask

  task automatic test_len_err();
    logic [8:0] o, e;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, o);
      e = {1'b1, 4'h2, i == 3, 2'b00, i == 3};
      total++;
      if (o !== e) $display("FAIL len_err d%0d got %h want %h", i, o, e);
      else passed++;
    end
    step(1'b0, 1'b1, 1'b0, 4'h1, 4'h1, 1'b1, o);
    e = {1'b1, 4'h2, 4'b1000};
    total++;
    if (o !== e) $display("FAIL len_err close got %h want %h", o, e);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [8:0] o, e;
    step(1'b0, 1'b1, 1'b1, 4'h3, 4'h1, 1'b0, o);
    step(1'b0, 1'b1, 1'b1, 4'h2, 4'h5, 1'b0, o);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, o);
    total++;
    if (o !== 9'h000) $display("FAIL reset_mid got %h want %h", o, 9'h000);
    else passed++;
    step(1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 1'b1, o);
    e = {1'b1, 4'h0, 4'b1100};
    total++;
    if (o !== e) $display("FAIL reset_mid after got %h want %h", o, e);
    else passed++;
  endtask

  task automatic test_random();
    logic [8:0] o;
    int  n, gaps;
    bit  mode, trunc;
    for (int w = 0; w < 80; w++) begin
      n     = $urandom_range(1, 4);
      trunc = (n == 4) && ($urandom_range(0, 2) == 0);
      mode  = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        wa[i] = 4'($urandom_range(0, 15));
        wb[i] = 4'($urandom_range(0, 15));
      end
      model_word(n, mode, trunc);
      for (int i = 0; i < n; i++) begin
        gaps = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
        for (int g = 0; g < gaps; g++) begin
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), o);
          total++;
          if (o !== 9'h000) $display("FAIL rand idle w%0d got %h want %h", w, o, 9'h000);
          else passed++;
        end
        step(1'b0, 1'b1, (i == 0) ? mode : 1'($urandom_range(0, 1)), wa[i], wb[i],
             (i == n - 1) && !trunc, o);
        total++;
        if (o !== ex[i]) $display("FAIL rand w%0d d%0d n%0d got %h want %h", w, i, n, o, ex[i]);
        else passed++;
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    vld  = 1'b0;
    sub  = 1'b0;
    a    = 4'h0;
    b    = 4'h0;
    last = 1'b0;
    test_reset();
    test_add_ripple();
    test_sub_borrow();
    test_ovf();
    test_gaps();
    test_len_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
